// File: rtl/gals_spike_encoder_v2.sv
// Frame-buffered ANN-to-SNN bridge: 4-phase pixel-vector input, time-to-first-spike
// AER output with optional sparsity, address offset and event counting.
module gals_spike_encoder_v2 #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned TIME_W        = 8,
    parameter int unsigned PIXEL_VEC_LEN = 8,
    parameter int unsigned NUM_PIXELS    = 20,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned T_MAX         = 127,
    parameter int unsigned SHIFT_BITS    = 2,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_data_req,
    output logic                              o_data_ack,
    input  logic [PIXEL_VEC_LEN*DATA_W-1:0]   i_data_bus,
    input  logic                              i_sparse_en,
    input  logic [DATA_W-1:0]                 i_zero_thresh,
    output logic                              o_aer_req,
    input  logic                              i_aer_ack,
    output logic [TIME_W-1:0]                 o_aer_time,
    output logic [ADDR_W-1:0]                 o_aer_addr,
    output logic                              o_encoder_done,
    output logic                              o_busy,
    output logic [ADDR_W:0]                   o_event_count
);

    localparam int unsigned VEC_LEN = PIXEL_VEC_LEN * NUM_PIXELS;
    localparam int unsigned IDX_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned PIX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int unsigned CW      = DATA_W + 1;

    typedef enum logic [2:0] {
        S_FILL,
        S_EVAL,
        S_REQ,
        S_WAIT_LOW,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [IDX_W-1:0]   r_elem;
    logic               r_sparse_q;
    logic               r_data_ack;
    logic               r_aer_req;
    logic [TIME_W-1:0]  r_aer_time;
    logic [ADDR_W-1:0]  r_aer_addr;
    logic               r_done;
    logic [ADDR_W:0]    r_event_count;
    logic [DATA_W-1:0]  r_buf [VEC_LEN];

    logic               w_req_s;
    logic               w_ack_s;
    logic               w_latch;
    logic               w_skip;
    logic               w_last;
    logic signed [CW-1:0] w_x;
    logic signed [CW-1:0] w_xp;
    logic signed [CW-1:0] w_t;
    logic signed [CW-1:0] w_tc;
    logic [TIME_W-1:0]  w_time;

    // Optional metastability chains on the two asynchronous handshake inputs
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_req_s = i_data_req;
            assign w_ack_s = i_aer_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_req_sync;
            logic [SYNC_STAGES-1:0] r_ack_sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_req_sync <= '0;
                    r_ack_sync <= '0;
                end else begin
                    r_req_sync <= SYNC_STAGES'({r_req_sync, i_data_req});
                    r_ack_sync <= SYNC_STAGES'({r_ack_sync, i_aer_ack});
                end
            end
            assign w_req_s = r_req_sync[SYNC_STAGES-1];
            assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_latch = (r_state == S_FILL) && w_req_s && !r_data_ack;
    assign w_last  = (r_elem == IDX_W'(VEC_LEN - 1));
    assign w_skip  = r_sparse_q && ($signed(r_buf[r_elem]) <= $signed(i_zero_thresh));

    // Frame buffer, pixel-major: element index = pixel*PIXEL_VEC_LEN + channel
    always_ff @(posedge clk) begin
        if (w_latch) begin
            for (int c = 0; c < PIXEL_VEC_LEN; c++) begin
                r_buf[IDX_W'(int'(r_pix_cnt) * PIXEL_VEC_LEN + c)] <= i_data_bus[c*DATA_W +: DATA_W];
            end
        end
    end

    // Spike time: negatives fire last, larger activations fire earlier
    always_comb begin
        w_x  = CW'($signed(r_buf[r_elem]));
        w_xp = w_x[CW-1] ? '0 : w_x;
        w_t  = $signed(CW'(T_MAX)) - (w_xp >>> SHIFT_BITS);
        w_tc = w_t;
        if (w_t[CW-1]) begin
            w_tc = '0;
        end else if (w_t > $signed(CW'(T_MAX))) begin
            w_tc = $signed(CW'(T_MAX));
        end
        w_time = TIME_W'($unsigned(w_tc));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_pix_cnt     <= '0;
            r_elem        <= '0;
            r_sparse_q    <= 1'b0;
            r_data_ack    <= 1'b0;
            r_aer_req     <= 1'b0;
            r_aer_time    <= '0;
            r_aer_addr    <= '0;
            r_done        <= 1'b0;
            r_event_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_req_s && !r_data_ack) begin
                        r_data_ack <= 1'b1;
                    end else if (!w_req_s && r_data_ack) begin
                        r_data_ack <= 1'b0;
                        if (r_pix_cnt == PIX_W'(NUM_PIXELS - 1)) begin
                            r_state       <= S_EVAL;
                            r_elem        <= '0;
                            r_event_count <= '0;
                            r_sparse_q    <= i_sparse_en;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (w_skip) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_elem <= r_elem + 1'b1;
                        end
                    end else begin
                        r_aer_time <= w_time;
                        r_aer_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_elem);
                        r_aer_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack_s) begin
                        r_aer_req     <= 1'b0;
                        r_event_count <= r_event_count + 1'b1;
                        r_state       <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!w_ack_s) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_elem  <= r_elem + 1'b1;
                            r_state <= S_EVAL;
                        end
                    end
                end
                S_DONE: begin
                    r_pix_cnt <= '0;
                    r_state   <= S_FILL;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign o_data_ack     = r_data_ack;
    assign o_aer_req      = r_aer_req;
    assign o_aer_time     = r_aer_time;
    assign o_aer_addr     = r_aer_addr;
    assign o_encoder_done = r_done;
    assign o_event_count  = r_event_count;
    assign o_busy         = !((r_state == S_FILL) && (r_pix_cnt == '0));

endmodule

// File: tb/tb_gals_spike_encoder_v2.sv
// Scoreboard bench: two encoder instances (no sync / base 0, two-stage sync / base 100),
// directed frames plus random frames checked against a plain-arithmetic TTFS model.
module tb_gals_spike_encoder_v2;

    typedef struct {
        int addr;
        int tm;
    } ev_t;

    logic        clk;
    logic        rst_main [2];
    logic        rst_mon;
    logic        data_req [2];
    logic        data_ack [2];
    logic [15:0] data_bus [2];
    logic        sparse_en [2];
    logic [7:0]  zthr [2];
    logic        aer_req [2];
    logic        aer_ack [2];
    logic [7:0]  aer_time [2];
    logic [9:0]  aer_addr [2];
    logic        done [2];
    logic        busy [2];
    logic [10:0] ev_cnt [2];

    ev_t exp_q [$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  frame_ev = 0;
    int  rst_after = 0;
    int  sel = 0;
    bit  long_next = 0;
    bit  rst_fired = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic rst_g;
        assign rst_g = rst_main[g] | (rst_mon && (sel == g));
        gals_spike_encoder_v2 #(
            .PIXEL_VEC_LEN (2),
            .NUM_PIXELS    (2),
            .BASE_ADDR     ((g == 0) ? 0 : 100),
            .SYNC_STAGES   ((g == 0) ? 0 : 2)
        ) u_dut (
            .clk            (clk),
            .rst            (rst_g),
            .i_data_req     (data_req[g]),
            .o_data_ack     (data_ack[g]),
            .i_data_bus     (data_bus[g]),
            .i_sparse_en    (sparse_en[g]),
            .i_zero_thresh  (zthr[g]),
            .o_aer_req      (aer_req[g]),
            .i_aer_ack      (aer_ack[g]),
            .o_aer_time     (aer_time[g]),
            .o_aer_addr     (aer_addr[g]),
            .o_encoder_done (done[g]),
            .o_busy         (busy[g]),
            .o_event_count  (ev_cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference: each element fires at T_MAX - floor(max(x,0)/4), skipped when sparse and x <= thresh
    task automatic push_model(int s, logic [15:0] b0, logic [15:0] b1, bit sp, logic [7:0] th, output int n);
        logic [15:0] beats [2];
        int x, thr, t;
        ev_t e;
        beats[0] = b0;
        beats[1] = b1;
        thr = $signed(th);
        n = 0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 2; c++) begin
                x = $signed(beats[p][c*8 +: 8]);
                if (!(sp && x <= thr)) begin
                    t = (x > 0) ? 127 - x / 4 : 127;
                    e.addr = ((s == 0) ? 0 : 100) + p * 2 + c;
                    e.tm   = t;
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
    endtask

    task automatic send_beat(int s, logic [15:0] b);
        int lat;
        data_bus[s] = b;
        data_req[s] = 1'b1;
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            lat++;
            if (data_ack[s]) break;
        end
        check("data_ack_rise", data_ack[s], 1);
        check("data_ack_latency", lat, (s == 0) ? 1 : 3);
        data_req[s] = 1'b0;
        for (int k = 0; k < 50 && data_ack[s]; k++) @(negedge clk);
        check("data_ack_fall", data_ack[s], 0);
    endtask

    task automatic wait_done(int s, int n, bit chk_ack);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done[s]) break;
            if (chk_ack) check("data_ack_held_low", data_ack[s], 0);
        end
        check("done_pulse", done[s], 1);
        frame_ev = 0;
        check("event_count", ev_cnt[s], n);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done[s], 0);
    endtask

    task automatic run_frame(int s, logic [15:0] b0, logic [15:0] b1, bit sp, logic [7:0] th);
        int n;
        sel = s;
        sparse_en[s] = sp;
        zthr[s] = th;
        push_model(s, b0, b1, sp, th, n);
        send_beat(s, b0);
        send_beat(s, b1);
        wait_done(s, n, 1'b0);
    endtask

    // Monitor: pops expected events, acknowledges with variable delay, checks hold and counts
    initial begin : monitor
        int s, dly, a0, t0, c0;
        ev_t e;
        aer_ack[0] = 1'b0;
        aer_ack[1] = 1'b0;
        rst_mon = 1'b0;
        forever begin
            @(negedge clk);
            if (aer_req[sel]) begin
                s  = sel;
                a0 = int'(aer_addr[s]);
                t0 = int'(aer_time[s]);
                c0 = int'(ev_cnt[s]);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: got addr %0d time %0d, required no event", a0, t0);
                end else begin
                    e = exp_q.pop_front();
                    check("aer_addr", a0, e.addr);
                    check("aer_time", t0, e.tm);
                end
                check("count_before_ack", c0, frame_ev);
                dly = $urandom_range(0, 3);
                if (long_next) dly = 10;
                long_next = 1'b0;
                repeat (dly) begin
                    @(negedge clk);
                    check("req_hold_stable",
                          (aer_req[s] && int'(aer_addr[s]) == a0 && int'(aer_time[s]) == t0 &&
                           int'(ev_cnt[s]) == c0) ? 1 : 0, 1);
                end
                aer_ack[s] = 1'b1;
                for (int k = 0; k < 20 && aer_req[s]; k++) @(negedge clk);
                check("aer_req_drop", aer_req[s], 0);
                frame_ev++;
                check("count_after_ack", ev_cnt[s], frame_ev);
                aer_ack[s] = 1'b0;
                if (rst_after != 0 && frame_ev == rst_after) begin
                    rst_mon = 1'b1;
                    @(negedge clk);
                    rst_mon = 1'b0;
                    check("rst_aer_req", aer_req[s], 0);
                    check("rst_count", ev_cnt[s], 0);
                    check("rst_busy", busy[s], 0);
                    check("rst_data_ack", data_ack[s], 0);
                    exp_q.delete();
                    frame_ev  = 0;
                    rst_after = 0;
                    rst_fired = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        logic [15:0] a0, a1, b0, b1;
        logic [7:0]  th;
        int n;
        a0 = {8'hF6, 8'h40};
        a1 = {8'h00, 8'h7F};
        for (int s = 0; s < 2; s++) begin
            rst_main[s]  = 1'b1;
            data_req[s]  = 1'b0;
            data_bus[s]  = '0;
            sparse_en[s] = 1'b0;
            zthr[s]      = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_data_ack", data_ack[s], 0);
            check("reset_aer_req", aer_req[s], 0);
            check("reset_aer_addr", aer_addr[s], 0);
            check("reset_aer_time", aer_time[s], 0);
            check("reset_done", done[s], 0);
            check("reset_busy", busy[s], 0);
            check("reset_count", ev_cnt[s], 0);
        end
        rst_main[0] = 1'b0;
        rst_main[1] = 1'b0;
        @(negedge clk);

        // dense, sparse, long ack hold
        run_frame(0, a0, a1, 1'b0, 8'd0);
        run_frame(0, a0, a1, 1'b1, 8'd0);
        long_next = 1'b1;
        run_frame(0, a0, a1, 1'b0, 8'd0);

        // input request during emission waits until after the done pulse
        sel = 0;
        sparse_en[0] = 1'b0;
        push_model(0, a0, a1, 1'b0, 8'd0, n);
        send_beat(0, a0);
        send_beat(0, a1);
        b0 = {8'h20, 8'hE0};
        b1 = {8'h80, 8'h04};
        data_bus[0] = b0;
        data_req[0] = 1'b1;
        wait_done(0, n, 1'b1);
        push_model(0, b0, b1, 1'b0, 8'd0, n);
        for (int k = 0; k < 50 && !data_ack[0]; k++) @(negedge clk);
        check("overlap_ack_rise", data_ack[0], 1);
        data_req[0] = 1'b0;
        for (int k = 0; k < 50 && data_ack[0]; k++) @(negedge clk);
        check("overlap_ack_fall", data_ack[0], 0);
        send_beat(0, b1);
        wait_done(0, n, 1'b0);

        // base offset with synchronisers, then reset mid-frame and recovery
        run_frame(1, a0, a1, 1'b0, 8'd0);
        sel = 1;
        sparse_en[1] = 1'b0;
        rst_after = 2;
        push_model(1, a0, a1, 1'b0, 8'd0, n);
        send_beat(1, a0);
        send_beat(1, a1);
        for (int k = 0; k < 3000 && !rst_fired; k++) @(negedge clk);
        check("rst_fired", rst_fired, 1);
        rst_fired = 1'b0;
        @(negedge clk);
        run_frame(1, a0, a1, 1'b0, 8'd0);

        // random frames on both instances, including fully skipped frames
        for (int r = 0; r < 24; r++) begin
            b0 = 16'($urandom);
            b1 = 16'($urandom);
            th = 8'($urandom_range(0, 60)) - 8'd20;
            if (r % 8 == 7) th = 8'h7F;
            run_frame(r % 2, b0, b1, 1'($urandom_range(0, 1)) | (r % 8 == 7), th);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
